// File: rtl/pc_seq_pkg.sv
// Shared types and default sizes for the program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int unsigned DDefault     = 10;
  localparam int unsigned DepthDefault = 4;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address stack for pc_sequencer (built only when PC_SEQ_RAS_EN is defined).
// Push is dropped when full, pop ignored when empty; clear empties the stack.
module ret_stack
  import pc_seq_pkg::*;
#(
  parameter int unsigned D     = DDefault,
  parameter int unsigned DEPTH = DepthDefault
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [D-1:0] din,
  output logic [D-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [D-1:0]  mem_q [DEPTH];
  logic [CW-1:0] count_q;
  logic [CW-1:0] top_cnt;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign top_cnt = count_q - CW'(1);
  assign rd_idx  = top_cnt[AW-1:0];
  assign wr_idx  = count_q[AW-1:0];
  assign top     = empty ? '0 : mem_q[rd_idx];

  // Storage needs no reset: entries above count_q are never read.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (push && !full) begin
      mem_q[wr_idx] <= din;
      count_q       <= count_q + CW'(1);
    end else if (pop && !empty) begin
      count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program sequencer steering an external PC via jumpEn/target.
// Define PC_SEQ_RAS_EN to build the return-address stack and ras_err tracking.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned D     = DDefault,
  parameter int unsigned DEPTH = DepthDefault
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         halt_req,
  input  logic         stall_req,
  input  logic         br_en,
  input  logic         br_cond,
  input  logic [D-1:0] br_target,
  input  logic         call_en,
  input  logic         ret_en,
  input  logic [D-1:0] pc_in,
  output logic         jumpEn,
  output logic [D-1:0] target,
  output logic         running,
  output logic         done,
  output logic         ras_err
);

  state_t state_q, state_d;
  logic   running_q, done_q;

`ifdef PC_SEQ_RAS_EN
  logic         push, pop, err_set;
  logic         ras_full, ras_empty;
  logic         ras_err_q;
  logic [D-1:0] ras_top, push_data;

  assign push_data = pc_in + D'(1);

  ret_stack #(
    .D    (D),
    .DEPTH(DEPTH)
  ) u_ret_stack (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .clear(start),
    .din  (push_data),
    .top  (ras_top),
    .full (ras_full),
    .empty(ras_empty)
  );

  always_ff @(posedge clk) begin
    if (reset || start) begin
      ras_err_q <= 1'b0;
    end else if (err_set) begin
      ras_err_q <= 1'b1;
    end
  end

  assign ras_err = ras_err_q;
`else
  logic unused_ret;
  localparam int unsigned unused_depth = DEPTH;
  assign unused_ret = ret_en;
  assign ras_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == RUN);
      done_q    <= (state_d == HALT);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (!start && halt_req && !stall_req) state_d = HALT;
      HALT:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Holding is expressed as an explicit jump to pc_in.
  always_comb begin
    jumpEn = 1'b1;
    target = pc_in;
`ifdef PC_SEQ_RAS_EN
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
`endif
    if (state_q == RUN && !stall_req && !halt_req) begin
`ifdef PC_SEQ_RAS_EN
      if (ret_en) begin
        if (ras_empty) begin
          jumpEn  = 1'b0;
          err_set = 1'b1;
        end else begin
          target = ras_top;
          pop    = 1'b1;
        end
      end else if (call_en) begin
        target = br_target;
        if (ras_full) err_set = 1'b1;
        else          push    = 1'b1;
      end
`else
      if (call_en) begin
        target = br_target;
      end
`endif
      else if (br_en && br_cond) begin
        target = br_target;
      end else begin
        jumpEn = 1'b0;
      end
    end
  end

  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer; expectations follow PC_SEQ_RAS_EN when defined.
module tb_pc_sequencer;

  localparam int D     = 10;
  localparam int DEPTH = 4;

`ifdef PC_SEQ_RAS_EN
  localparam bit R = 1'b1;
`else
  localparam bit R = 1'b0;
`endif

  localparam logic [7:0] RST = 8'h80, ST = 8'h40, HR = 8'h20, SR = 8'h10;
  localparam logic [7:0] BE  = 8'h08, BC = 8'h04, CE = 8'h02, RE = 8'h01;

  typedef struct {
    string      name;
    logic [7:0] ctrl;
    logic [9:0] bt;
    logic [9:0] pc;
    logic       chk;
    logic       jen;
    logic [9:0] tgt;
    logic       run;
    logic       dn;
    logic       err;
  } row_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0, halt_req = 1'b0, stall_req = 1'b0;
  logic         br_en = 1'b0, br_cond = 1'b0, call_en = 1'b0, ret_en = 1'b0;
  logic [D-1:0] br_target = '0;
  logic [D-1:0] pc_in, pc_drv = '0, pc_q = '0;
  logic         use_model = 1'b0;
  logic         jumpEn, running, done, ras_err;
  logic [D-1:0] target;

  int total = 0;
  int bad   = 0;
  row_t sb[$];

  assign pc_in = use_model ? pc_q : pc_drv;

  always #5 clk = ~clk;

  // Simple PC: start/reset zero it, otherwise jump or increment.
  always @(posedge clk) begin
    if (reset || start) pc_q <= '0;
    else if (jumpEn)    pc_q <= target;
    else                pc_q <= pc_q + 10'd1;
  end

  pc_sequencer #(
    .D    (D),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .halt_req (halt_req),
    .stall_req(stall_req),
    .br_en    (br_en),
    .br_cond  (br_cond),
    .br_target(br_target),
    .call_en  (call_en),
    .ret_en   (ret_en),
    .pc_in    (pc_in),
    .jumpEn   (jumpEn),
    .target   (target),
    .running  (running),
    .done     (done),
    .ras_err  (ras_err)
  );

  function automatic row_t mk(input string name, input logic [7:0] ctrl, input logic [9:0] bt,
                              input logic [9:0] pc, input logic jen, input logic [9:0] tgt,
                              input logic run, input logic dn, input logic err);
    row_t r;
    r.name = name; r.ctrl = ctrl; r.bt = bt; r.pc = pc; r.chk = !ctrl[7];
    r.jen = jen; r.tgt = tgt; r.run = run; r.dn = dn; r.err = err;
    return r;
  endfunction

  task automatic drive(input row_t r);
    reset     = r.ctrl[7];
    start     = r.ctrl[6];
    halt_req  = r.ctrl[5];
    stall_req = r.ctrl[4];
    br_en     = r.ctrl[3];
    br_cond   = r.ctrl[2];
    call_en   = r.ctrl[1];
    ret_en    = r.ctrl[0];
    br_target = r.bt;
    pc_drv    = r.pc;
  endtask

  task automatic test_reset();
    row_t rows[$];
    row_t e;
    logic [9:0] tobs;
    rows.push_back(mk("rst_a", RST | ST | CE, 10'h055, 10'h123, 0, 0, 0, 0, 0));
    rows.push_back(mk("rst_b", RST | ST, 10'h055, 10'h123, 0, 0, 0, 0, 0));
    rows.push_back(mk("reset_idle", 8'h00, 10'h000, 10'h123, 1, 10'h123, 0, 0, 0));
    rows.push_back(mk("idle_hold", BE | BC | CE, 10'h077, 10'h124, 1, 10'h124, 0, 0, 0));
    foreach (rows[i]) begin
      @(negedge clk);
      drive(rows[i]);
      if (rows[i].chk) sb.push_back(rows[i]);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        tobs = e.jen ? target : e.tgt;
        total++;
        if ({jumpEn, tobs, running, done, ras_err} !== {e.jen, e.tgt, e.run, e.dn, e.err}) begin
          bad++;
          $display("FAIL %s: got jen=%b tgt=%h run=%b done=%b err=%b, want %b %h %b %b %b",
                   e.name, jumpEn, target, running, done, ras_err,
                   e.jen, e.tgt, e.run, e.dn, e.err);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_count();
    logic [9:0] exp_pc;
    @(negedge clk);
    drive(mk("start", ST, 10'h000, 10'h000, 1, 10'h000, 0, 0, 0));
    #1;
    total++;
    if ({jumpEn, target, running} !== {1'b1, 10'h000, 1'b0}) begin
      bad++;
      $display("FAIL start_idle: got jen=%b tgt=%h run=%b, want 1 000 0", jumpEn, target, running);
    end
    @(posedge clk);
    #1;
    use_model = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(mk("count", 8'h00, 10'h000, 10'h000, 0, 0, 1, 0, 0));
      exp_pc = 10'(i);
      #1;
      total++;
      if ({pc_in, jumpEn, running} !== {exp_pc, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL count%0d: got pc=%h jen=%b run=%b, want pc=%h jen=0 run=1",
                 i, pc_in, jumpEn, running, exp_pc);
      end
      @(posedge clk);
      #1;
    end
    use_model = 1'b0;
  endtask

  task automatic test_branch();
    row_t rows[$];
    row_t e;
    logic [9:0] tobs;
    rows.push_back(mk("br_taken", BE | BC, 10'h200, 10'h005, 1, 10'h200, 1, 0, 0));
    rows.push_back(mk("br_not_taken", BE, 10'h200, 10'h006, 0, 0, 1, 0, 0));
    rows.push_back(mk("cond_no_br", BC, 10'h200, 10'h007, 0, 0, 1, 0, 0));
    foreach (rows[i]) begin
      @(negedge clk);
      drive(rows[i]);
      sb.push_back(rows[i]);
      #1;
      e = sb.pop_front();
      tobs = e.jen ? target : e.tgt;
      total++;
      if ({jumpEn, tobs, running, done, ras_err} !== {e.jen, e.tgt, e.run, e.dn, e.err}) begin
        bad++;
        $display("FAIL %s: got jen=%b tgt=%h run=%b done=%b err=%b, want %b %h %b %b %b",
                 e.name, jumpEn, target, running, done, ras_err,
                 e.jen, e.tgt, e.run, e.dn, e.err);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_call_ret();
    row_t rows[$];
    row_t e;
    logic [9:0] tobs;
    rows.push_back(mk("call", CE, 10'h080, 10'h010, 1, 10'h080, 1, 0, 0));
    rows.push_back(mk("after_call", 8'h00, 10'h000, 10'h080, 0, 0, 1, 0, 0));
    rows.push_back(mk("ret", RE, 10'h000, 10'h081, R, 10'h011, 1, 0, 0));
    rows.push_back(mk("call2", CE, 10'h100, 10'h020, 1, 10'h100, 1, 0, 0));
    rows.push_back(mk("ret_call", RE | CE, 10'h300, 10'h100, 1, R ? 10'h021 : 10'h300, 1, 0, 0));
    rows.push_back(mk("ret_empty", RE, 10'h000, 10'h101, 0, 0, 1, 0, 0));
    rows.push_back(mk("err_set", 8'h00, 10'h000, 10'h102, 0, 0, 1, 0, R));
    rows.push_back(mk("start_run", ST, 10'h000, 10'h103, 0, 0, 1, 0, R));
    rows.push_back(mk("err_clr", 8'h00, 10'h000, 10'h000, 0, 0, 1, 0, 0));
    foreach (rows[i]) begin
      @(negedge clk);
      drive(rows[i]);
      sb.push_back(rows[i]);
      #1;
      e = sb.pop_front();
      tobs = e.jen ? target : e.tgt;
      total++;
      if ({jumpEn, tobs, running, done, ras_err} !== {e.jen, e.tgt, e.run, e.dn, e.err}) begin
        bad++;
        $display("FAIL %s: got jen=%b tgt=%h run=%b done=%b err=%b, want %b %h %b %b %b",
                 e.name, jumpEn, target, running, done, ras_err,
                 e.jen, e.tgt, e.run, e.dn, e.err);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_overflow();
    row_t rows[$];
    row_t e;
    logic [9:0] tobs;
    for (int i = 0; i <= DEPTH; i++) begin
      rows.push_back(mk($sformatf("ovf_call%0d", i), CE, 10'(32'h200 + i), 10'(32'h100 + i),
                        1, 10'(32'h200 + i), 1, 0, 0));
    end
    for (int j = 0; j <= DEPTH; j++) begin
      rows.push_back(mk($sformatf("ovf_ret%0d", j), RE, 10'h000, 10'(32'h300 + j),
                        R && (j < DEPTH), 10'(32'h100 + DEPTH - j), 1, 0, R));
    end
    rows.push_back(mk("err_sticky", 8'h00, 10'h000, 10'h310, 0, 0, 1, 0, R));
    rows.push_back(mk("ovf_start", ST, 10'h000, 10'h311, 0, 0, 1, 0, R));
    rows.push_back(mk("ovf_clr", 8'h00, 10'h000, 10'h000, 0, 0, 1, 0, 0));
    foreach (rows[i]) begin
      @(negedge clk);
      drive(rows[i]);
      sb.push_back(rows[i]);
      #1;
      e = sb.pop_front();
      tobs = e.jen ? target : e.tgt;
      total++;
      if ({jumpEn, tobs, running, done, ras_err} !== {e.jen, e.tgt, e.run, e.dn, e.err}) begin
        bad++;
        $display("FAIL %s: got jen=%b tgt=%h run=%b done=%b err=%b, want %b %h %b %b %b",
                 e.name, jumpEn, target, running, done, ras_err,
                 e.jen, e.tgt, e.run, e.dn, e.err);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_wrap_stall_halt();
    row_t rows[$];
    row_t e;
    logic [9:0] tobs;
    rows.push_back(mk("wrap_call", CE, 10'h050, 10'h3FF, 1, 10'h050, 1, 0, 0));
    rows.push_back(mk("wrap_ret", RE, 10'h000, 10'h050, R, 10'h000, 1, 0, 0));
    rows.push_back(mk("stall_halt", SR | HR | CE, 10'h0AA, 10'h055, 1, 10'h055, 1, 0, 0));
    rows.push_back(mk("no_push", RE, 10'h000, 10'h056, 0, 0, 1, 0, 0));
    rows.push_back(mk("halt_req", HR, 10'h000, 10'h060, 1, 10'h060, 1, 0, R));
    rows.push_back(mk("halted", 8'h00, 10'h000, 10'h061, 1, 10'h061, 0, 1, R));
    rows.push_back(mk("halt_call", CE, 10'h0BB, 10'h062, 1, 10'h062, 0, 1, R));
    rows.push_back(mk("halt_start", ST, 10'h000, 10'h063, 1, 10'h063, 0, 1, R));
    rows.push_back(mk("rerun", 8'h00, 10'h000, 10'h000, 0, 0, 1, 0, 0));
    foreach (rows[i]) begin
      @(negedge clk);
      drive(rows[i]);
      sb.push_back(rows[i]);
      #1;
      e = sb.pop_front();
      tobs = e.jen ? target : e.tgt;
      total++;
      if ({jumpEn, tobs, running, done, ras_err} !== {e.jen, e.tgt, e.run, e.dn, e.err}) begin
        bad++;
        $display("FAIL %s: got jen=%b tgt=%h run=%b done=%b err=%b, want %b %h %b %b %b",
                 e.name, jumpEn, target, running, done, ras_err,
                 e.jen, e.tgt, e.run, e.dn, e.err);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid();
    row_t rows[$];
    row_t e;
    logic [9:0] tobs;
    rows.push_back(mk("mid_call", CE, 10'h090, 10'h030, 1, 10'h090, 1, 0, 0));
    rows.push_back(mk("mid_rst", RST | CE, 10'h0A0, 10'h090, 0, 0, 0, 0, 0));
    rows.push_back(mk("mid_idle", 8'h00, 10'h000, 10'h0C0, 1, 10'h0C0, 0, 0, 0));
    rows.push_back(mk("mid_start", ST, 10'h000, 10'h0C1, 1, 10'h0C1, 0, 0, 0));
    rows.push_back(mk("mid_ret", RE, 10'h000, 10'h005, 0, 0, 1, 0, 0));
    rows.push_back(mk("mid_err", 8'h00, 10'h000, 10'h006, 0, 0, 1, 0, R));
    foreach (rows[i]) begin
      @(negedge clk);
      drive(rows[i]);
      if (rows[i].chk) sb.push_back(rows[i]);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        tobs = e.jen ? target : e.tgt;
        total++;
        if ({jumpEn, tobs, running, done, ras_err} !== {e.jen, e.tgt, e.run, e.dn, e.err}) begin
          bad++;
          $display("FAIL %s: got jen=%b tgt=%h run=%b done=%b err=%b, want %b %h %b %b %b",
                   e.name, jumpEn, target, running, done, ras_err,
                   e.jen, e.tgt, e.run, e.dn, e.err);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_count();
    test_branch();
    test_call_ret();
    test_overflow();
    test_wrap_stall_halt();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
